// File: rtl/cic_int.sv
// CIC interpolator integrator section: N cascaded high-rate accumulators, then scaling of the last one.
// Optional build macro CIC_ROUND_EN: round-half-up plus saturation with a sticky ovf flag.
module cic_int #(
  parameter int Win   = 19,
  parameter int N     = 3,
  parameter int Wacc  = 52,
  parameter int Wout  = 19,
  parameter int SHIFT = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   val_in,
  input  logic signed [Win-1:0]  data_in,
  output logic                   val_out,
  output logic signed [Wout-1:0] data_out,
  output logic                   ovf
);

  localparam int FW = $clog2(N + 1);

  logic signed [Wacc-1:0] r_integ_p0 [N];
  logic [FW-1:0]          r_fcnt_p0;
  logic signed [Wout-1:0] r_data_p1;
  logic                   r_vld_p1;
  logic signed [Wacc-1:0] w_din_ext;
  logic signed [Wacc-1:0] w_last;
  logic signed [Wout-1:0] w_scaled;

  function automatic logic signed [Wout-1:0] trunc_sel(input logic signed [Wacc-1:0] v);
    return v[SHIFT+Wout-1:SHIFT];
  endfunction

`ifdef CIC_ROUND_EN
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [Wacc-1:0] HALF = (SHIFT > 0) ? (Wacc'(1) << RSH) : '0;

  logic signed [Wacc-1:0] w_rnd;
  logic                   w_sat;
  logic                   r_ovf;

  function automatic logic signed [Wacc-1:0] round_half_up(input logic signed [Wacc-1:0] v);
    return v + HALF;
  endfunction

  // Bits from the output sign position upward must all agree, else the value does not fit.
  function automatic logic sat_needed(input logic signed [Wacc-1:0] v);
    logic [Wacc-SHIFT-Wout:0] top;
    top = v[Wacc-1:SHIFT+Wout-1];
    return !((&top) || (~|top));
  endfunction

  function automatic logic signed [Wout-1:0] sat_value(input logic signed [Wacc-1:0] v);
    return v[Wacc-1] ? {1'b1, {(Wout-1){1'b0}}} : {1'b0, {(Wout-1){1'b1}}};
  endfunction

  assign w_rnd    = round_half_up(w_last);
  assign w_sat    = sat_needed(w_rnd);
  assign w_scaled = w_sat ? sat_value(w_rnd) : trunc_sel(w_rnd);
  assign ovf      = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_ovf <= 1'b0;
    else if (clr)            r_ovf <= 1'b0;
    else if (val_in && w_sat) r_ovf <= 1'b1;
  end
`else
  assign w_scaled = trunc_sel(w_last);
  assign ovf      = 1'b0;
`endif

  assign w_din_ext = Wacc'(data_in);
  assign w_last    = r_integ_p0[N-1];

  // Stage p0: integrator cascade, each stage fed by the pre-edge value of its predecessor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) r_integ_p0[k] <= '0;
      r_fcnt_p0 <= '0;
    end else if (clr) begin
      for (int k = 0; k < N; k++) r_integ_p0[k] <= '0;
      r_fcnt_p0 <= '0;
    end else if (val_in) begin
      r_integ_p0[0] <= r_integ_p0[0] + w_din_ext;
      for (int k = 1; k < N; k++) r_integ_p0[k] <= r_integ_p0[k] + r_integ_p0[k-1];
      if (r_fcnt_p0 != FW'(N)) r_fcnt_p0 <= r_fcnt_p0 + FW'(1);
    end
  end

  // Stage p1: registered scaled output and strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (clr) begin
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (val_in) begin
      r_data_p1 <= w_scaled;
      r_vld_p1  <= (r_fcnt_p0 == FW'(N));
    end else begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign data_out = r_data_p1;
  assign val_out  = r_vld_p1;

endmodule

// File: tb/tb_cic_int.sv
// Bench for cic_int: directed vector table, reset/clr/saturation sequences, random run vs binomial model.
module tb_cic_int;
  localparam int NN = 3;

  logic clk = 1'b0;
  logic rst, clr, val_in;
  logic signed [18:0] data_in;
  logic vo_a, vo_b, ovf_a, ovf_b;
  logic signed [23:0] da_a;
  logic signed [7:0]  db_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cic_int #(.Win(19), .N(NN), .Wacc(24), .Wout(24), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .val_in(val_in), .data_in(data_in),
    .val_out(vo_a), .data_out(da_a), .ovf(ovf_a));

  cic_int #(.Win(19), .N(NN), .Wacc(24), .Wout(8), .SHIFT(4)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .val_in(val_in), .data_in(data_in),
    .val_out(vo_b), .data_out(db_b), .ovf(ovf_b));

  // Model: last integrator before the m-th acceptance = sum_j x[j] * C(m-1-j, N-1)
  longint hist[$];
  int     mf;
  bit     m_vo, m_ovf;
  longint m_da, m_db;

  function automatic longint binom(int a, int b);
    longint r = 1;
    if (a < b || a < 0) return 0;
    for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
    return r;
  endfunction

  task automatic model_step(input bit c, input bit v, input int d);
    longint s;
    logic [63:0] sv;
    logic [23:0] acc, rnd;
    int m;
    if (c) begin
      hist.delete(); mf = 0; m_vo = 0; m_da = 0; m_db = 0; m_ovf = 0;
    end else if (v) begin
      s = 0;
      m = hist.size();
      for (int j = 0; j < m; j++) s += hist[j] * binom(m - 1 - j, NN - 1);
      sv  = s;
      acc = sv[23:0];
      m_vo = (mf == NN);
      if (mf < NN) mf++;
      m_da = longint'($signed(acc));
`ifdef CIC_ROUND_EN
      rnd = acc + 24'd8;
      if (!((&rnd[23:11]) || (~|rnd[23:11]))) begin
        m_db = rnd[23] ? -128 : 127;
        m_ovf = 1;
      end else begin
        m_db = longint'($signed(rnd[11:4]));
      end
`else
      rnd = acc;
      m_db = longint'($signed(rnd[11:4]));
`endif
      hist.push_back(longint'(d));
    end else begin
      m_vo = 0;
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input bit c, input bit v, input int d);
    logic [31:0] dv;
    dv = d;
    clr = c; val_in = v; data_in = dv[18:0];
    @(posedge clk);
    model_step(c, v, d);
    #1;
  endtask

  typedef struct {
    bit c; bit v; int d; bit evo; int eda;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // impulse, continuous
    tbl.push_back('{0,1,1,0,0});  tbl.push_back('{0,1,0,0,0});  tbl.push_back('{0,1,0,0,0});
    tbl.push_back('{0,1,0,1,1});  tbl.push_back('{0,1,0,1,3});  tbl.push_back('{0,1,0,1,6});
    tbl.push_back('{0,1,0,1,10}); tbl.push_back('{0,1,0,1,15}); tbl.push_back('{0,1,0,1,21});
    tbl.push_back('{1,1,5,0,0});
    // step
    tbl.push_back('{0,1,1,0,0});  tbl.push_back('{0,1,1,0,0});  tbl.push_back('{0,1,1,0,0});
    tbl.push_back('{0,1,1,1,1});  tbl.push_back('{0,1,1,1,4});  tbl.push_back('{0,1,1,1,10});
    tbl.push_back('{0,1,1,1,20}); tbl.push_back('{0,1,1,1,35});
    tbl.push_back('{1,0,0,0,0});
    // impulse with gaps; junk data on idle cycles must be ignored
    tbl.push_back('{0,1,1,0,0});  tbl.push_back('{0,0,7,0,0});  tbl.push_back('{0,1,0,0,0});
    tbl.push_back('{0,0,7,0,0});  tbl.push_back('{0,1,0,0,0});  tbl.push_back('{0,0,7,0,0});
    tbl.push_back('{0,1,0,1,1});  tbl.push_back('{0,0,7,0,1});  tbl.push_back('{0,1,0,1,3});
    tbl.push_back('{0,0,7,0,3});  tbl.push_back('{0,1,0,1,6});  tbl.push_back('{0,0,7,0,6});
    // clr mid-stream drops its own sample
    tbl.push_back('{1,1,9,0,0});
    tbl.push_back('{0,1,2,0,0});  tbl.push_back('{0,1,2,0,0});  tbl.push_back('{0,1,2,0,0});
    tbl.push_back('{0,1,2,1,2});  tbl.push_back('{0,1,2,1,8});

    rst = 1'b0; clr = 1'b0; val_in = 1'b0; data_in = '0;
    model_step(1, 0, 0);
    #12;
    chk("rst_vo_a", vo_a, 0);
    chk("rst_da_a", da_a, 0);
    chk("rst_db_b", db_b, 0);
    chk("rst_ovf_b", ovf_b, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      tick(tbl[i].c, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_vo", i), vo_a, tbl[i].evo);
      chk($sformatf("tbl%0d_da", i), da_a, tbl[i].eda);
    end

    // asynchronous reset between edges during continuous input
    for (int i = 0; i < 6; i++) tick(0, 1, 1);
    chk("pre_rst_vo", vo_a, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_vo_a", vo_a, 0);
    chk("arst_da_a", da_a, 0);
    chk("arst_vo_b", vo_b, 0);
    chk("arst_ovf_b", ovf_b, 0);
    model_step(1, 0, 0);
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1);
      chk($sformatf("rel%0d_vo", i), vo_a, (i == 3) ? 1 : 0);
    end
    chk("rel_da", da_a, 1);

    // constant large input into the narrow-output instance
    tick(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 100);
      chk($sformatf("k100_%0d_db", i), db_b, m_db);
      chk($sformatf("k100_%0d_ovf", i), ovf_b, m_ovf);
    end
`ifdef CIC_ROUND_EN
    chk("sat_db", db_b, 127);
    chk("sat_ovf", ovf_b, 1);
`else
    chk("wrap_ovf", ovf_b, 0);
    chk("wrap_da_a", da_a, m_da);
`endif
    tick(1, 0, 0);
    chk("clr_ovf", ovf_b, 0);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      bit c, v;
      int d;
      c = ($urandom_range(0, 39) == 0);
      v = $urandom_range(0, 1);
      d = int'($urandom_range(0, (1 << 19) - 1)) - (1 << 18);
      tick(c, v, d);
      chk("rnd_vo_a", vo_a, m_vo);
      chk("rnd_da_a", da_a, m_da);
      chk("rnd_vo_b", vo_b, m_vo);
      chk("rnd_db_b", db_b, m_db);
      chk("rnd_ovf_b", ovf_b, m_ovf);
      chk("rnd_ovf_a", ovf_a, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
